// File: rtl/reaction_ctrl_pkg.sv
// Shared types and default sizing for the reaction timer controller.
// The state enum is common to the controller and anything that decodes its phase.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    GO,
    DONE,
    EARLY,
    TOUT
  } rc_state_t;

  localparam int unsigned DEF_TICK_DIV = 100000;
  localparam int unsigned DEF_MAX_MS   = 9999;
  localparam int unsigned DEF_TIME_W   = 14;

endpackage

// File: rtl/reaction_ctrl_ms_tick_gen.sv
// Millisecond prescaler: emits a one-cycle tick every TICK_DIV clocks.
// A synchronous clear restarts the period so the first tick lands TICK_DIV cycles later.
module ms_tick_gen
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction timer sequencer: random wait, GO indication, millisecond response measurement.
// Outputs are registered and change on the same edge as the state transition that sets them.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned MAX_MS   = DEF_MAX_MS,
  parameter int unsigned TIME_W   = DEF_TIME_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_btn,
  input  logic              stop_btn,
  input  logic              rwait_done,
  output logic              start_rwait,
  output logic              led_go,
  output logic [TIME_W-1:0] rtime,
  output logic              rtime_valid,
  output logic              early,
  output logic              timeout,
  output logic              busy
);

  localparam logic [TIME_W-1:0] MS_LIMIT = TIME_W'(MAX_MS);

  rc_state_t         r_state;
  logic [TIME_W-1:0] r_msCount;
  logic [TIME_W-1:0] r_rtime;
  logic              r_startRwait;
  logic              r_ledGo;
  logic              r_rtimeValid;
  logic              r_early;
  logic              r_timeout;
  logic              r_busy;

  logic              w_tick;
  logic              w_tickClr;

  // Restart the prescaler on the very edge that enters GO, so the first tick is a full period away.
  assign w_tickClr = (r_state == WAIT) && !stop_btn && rwait_done;

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (w_tickClr),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_msCount    <= '0;
      r_rtime      <= '0;
      r_startRwait <= 1'b0;
      r_ledGo      <= 1'b0;
      r_rtimeValid <= 1'b0;
      r_early      <= 1'b0;
      r_timeout    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE, EARLY, TOUT: begin
          if (start_btn) begin
            r_state      <= WAIT;
            r_startRwait <= 1'b1;
            r_busy       <= 1'b1;
            r_rtimeValid <= 1'b0;
            r_early      <= 1'b0;
            r_timeout    <= 1'b0;
          end
        end
        // A press in the same cycle as wait expiry is a foul: GO was never visible.
        WAIT: begin
          if (stop_btn) begin
            r_state      <= EARLY;
            r_startRwait <= 1'b0;
            r_busy       <= 1'b0;
            r_early      <= 1'b1;
            r_rtime      <= '0;
          end else if (rwait_done) begin
            r_state      <= GO;
            r_startRwait <= 1'b0;
            r_ledGo      <= 1'b1;
            r_msCount    <= '0;
          end
        end
        GO: begin
          if (stop_btn) begin
            r_state      <= DONE;
            r_ledGo      <= 1'b0;
            r_busy       <= 1'b0;
            r_rtimeValid <= 1'b1;
            r_rtime      <= r_msCount;
          end else if (w_tick) begin
            if (r_msCount == MS_LIMIT) begin
              r_state   <= TOUT;
              r_ledGo   <= 1'b0;
              r_busy    <= 1'b0;
              r_timeout <= 1'b1;
              r_rtime   <= MS_LIMIT;
            end else begin
              r_msCount <= r_msCount + TIME_W'(1);
            end
          end
        end
        default: begin
          r_state      <= IDLE;
          r_startRwait <= 1'b0;
          r_ledGo      <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign start_rwait = r_startRwait;
  assign led_go      = r_ledGo;
  assign rtime       = r_rtime;
  assign rtime_valid = r_rtimeValid;
  assign early       = r_early;
  assign timeout     = r_timeout;
  assign busy        = r_busy;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl: directed rounds plus random button traffic against a round-level model.
// The model tracks whether a round is waiting or running and derives ms from elapsed GO cycles.
module tb_reaction_ctrl;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned MAX_MS   = 20;
  localparam int unsigned TIME_W   = 14;

  logic              clk;
  logic              reset;
  logic              start_btn;
  logic              stop_btn;
  logic              rwait_done;
  logic              start_rwait;
  logic              led_go;
  logic [TIME_W-1:0] rtime;
  logic              rtime_valid;
  logic              early;
  logic              timeout;
  logic              busy;

  int checkCount;
  int passCount;

  // Round-level model state
  bit mWaiting;
  bit mGoing;
  int mGoCycles;
  int mRtime;
  bit mRtimeKnown;
  bit mValid;
  bit mEarly;
  bit mTimeout;

  reaction_ctrl #(
    .TICK_DIV(TICK_DIV),
    .MAX_MS  (MAX_MS),
    .TIME_W  (TIME_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_btn  (start_btn),
    .stop_btn   (stop_btn),
    .rwait_done (rwait_done),
    .start_rwait(start_rwait),
    .led_go     (led_go),
    .rtime      (rtime),
    .rtime_valid(rtime_valid),
    .early      (early),
    .timeout    (timeout),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic resetModel();
    mWaiting    = 1'b0;
    mGoing      = 1'b0;
    mGoCycles   = 0;
    mRtime      = 0;
    mRtimeKnown = 1'b1;
    mValid      = 1'b0;
    mEarly      = 1'b0;
    mTimeout    = 1'b0;
  endtask

  // Advances the model across one rising edge given the inputs sampled there.
  task automatic modelEdge(input bit s, input bit p, input bit d);
    int msBefore;
    bit tickNow;
    if (mWaiting) begin
      if (p) begin
        mWaiting    = 1'b0;
        mEarly      = 1'b1;
        mRtime      = 0;
        mRtimeKnown = 1'b1;
      end else if (d) begin
        mWaiting  = 1'b0;
        mGoing    = 1'b1;
        mGoCycles = 0;
      end
    end else if (mGoing) begin
      mGoCycles++;
      msBefore = (mGoCycles - 1) / TICK_DIV;
      tickNow  = (mGoCycles % TICK_DIV) == 0;
      if (p) begin
        mGoing      = 1'b0;
        mValid      = 1'b1;
        mRtime      = msBefore;
        mRtimeKnown = 1'b1;
      end else if (tickNow && msBefore == int'(MAX_MS)) begin
        mGoing      = 1'b0;
        mTimeout    = 1'b1;
        mRtime      = MAX_MS;
        mRtimeKnown = 1'b1;
      end
    end else if (s) begin
      mWaiting    = 1'b1;
      mValid      = 1'b0;
      mEarly      = 1'b0;
      mTimeout    = 1'b0;
      mRtimeKnown = 1'b0;
    end
  endtask

  task automatic checkAll();
    checkOutput("start_rwait", int'(start_rwait), int'(mWaiting));
    checkOutput("led_go", int'(led_go), int'(mGoing));
    checkOutput("busy", int'(busy), int'(mWaiting | mGoing));
    checkOutput("rtime_valid", int'(rtime_valid), int'(mValid));
    checkOutput("early", int'(early), int'(mEarly));
    checkOutput("timeout", int'(timeout), int'(mTimeout));
    if (mRtimeKnown) checkOutput("rtime", int'(rtime), mRtime);
  endtask

  // One clock of stimulus: check settled outputs, drive inputs, then step the model over the edge.
  task automatic applyStimulus(input bit s, input bit p, input bit d);
    @(negedge clk);
    checkAll();
    start_btn  = s;
    stop_btn   = p;
    rwait_done = d;
    @(posedge clk);
    modelEdge(s, p, d);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    start_btn  = 1'b0;
    stop_btn   = 1'b0;
    rwait_done = 1'b0;
    reset      = 1'b1;
    resetModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAll();
    checkOutput("reset_rtime", int'(rtime), 0);
    reset = 1'b0;
    idleCycles(2);

    // Normal round
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(9);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idleCycles(29);
    applyStimulus(1'b0, 1'b1, 1'b0);
    settle();
    checkOutput("normal_rtime", int'(rtime), 7);
    checkOutput("normal_valid", int'(rtime_valid), 1);
    checkOutput("normal_led_go", int'(led_go), 0);
    checkOutput("normal_early", int'(early), 0);
    idleCycles(3);

    // Early press during the wait
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(4);
    applyStimulus(1'b0, 1'b1, 1'b0);
    settle();
    checkOutput("early_flag", int'(early), 1);
    checkOutput("early_rwait", int'(start_rwait), 0);
    checkOutput("early_rtime", int'(rtime), 0);
    idleCycles(3);

    // Press and wait expiry together
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    settle();
    checkOutput("simul_early", int'(early), 1);
    checkOutput("simul_led_go", int'(led_go), 0);
    idleCycles(3);

    // No response until timeout
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idleCycles(83);
    settle();
    checkOutput("tout_not_yet", int'(timeout), 0);
    idleCycles(1);
    settle();
    checkOutput("tout_flag", int'(timeout), 1);
    checkOutput("tout_rtime", int'(rtime), int'(MAX_MS));
    checkOutput("tout_valid", int'(rtime_valid), 0);
    checkOutput("tout_busy", int'(busy), 0);
    idleCycles(3);

    // Stop coincident with the fifth tick
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idleCycles(19);
    applyStimulus(1'b0, 1'b1, 1'b0);
    settle();
    checkOutput("tick_edge_rtime", int'(rtime), 4);
    idleCycles(2);

    // Reset mid-GO, then a full round with ignored start presses
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idleCycles(10);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    resetModel();
    checkOutput("rst_led_go", int'(led_go), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_rwait", int'(start_rwait), 0);
    checkOutput("rst_rtime", int'(rtime), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idleCycles(5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    settle();
    checkOutput("restart_valid", int'(rtime_valid), 1);
    checkOutput("restart_rtime", int'(rtime), 2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("restart_rwait", int'(start_rwait), 1);
    checkOutput("restart_valid_clr", int'(rtime_valid), 0);
    idleCycles(2);

    // Random button traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(99) < 6, $urandom_range(99) < 4, $urandom_range(99) < 8);
    end
    idleCycles(1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
